// File: rtl/grab_tile_pkg.sv
// Shared constants and types for the tile grab path: framebuffer geometry,
// clip key colour, address width and the grab FSM encoding.
package grab_tile_pkg;

  localparam int          ADDR_W    = 19;
  localparam int          FB_W      = 640;
  localparam int          FB_H      = 480;
  localparam logic [15:0] KEY_COLOR = 16'hF81F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

endpackage

// File: rtl/grab_addr_gen.sv
// Maps (tile origin, pixel counter) to a framebuffer address and a clip flag.
// Bounds checking is compiled in only when GRAB_TILE_CLIP_EN is defined.
module grab_addr_gen
  import grab_tile_pkg::*;
#(
  parameter int TILE_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] src_addr,
  output logic              clip
);

  localparam int COL_W = $clog2(TILE_W);

  // 11-bit coordinates so a tile hanging past the framebuffer edge is visible.
  logic [10:0]       col;
  logic [10:0]       row;
  logic [ADDR_W-1:0] row_base;

  always_comb begin
    col      = {1'b0, x} + 11'(cnt[COL_W-1:0]);
    row      = {1'b0, y} + 11'(cnt >> COL_W);
    row_base = ADDR_W'(row) * ADDR_W'(FB_W);
    src_addr = row_base + ADDR_W'(col);
  end

`ifdef GRAB_TILE_CLIP_EN
  assign clip = (col >= 11'(FB_W)) || (row >= 11'(FB_H));
`else
  assign clip = 1'b0;
`endif

endmodule

// File: rtl/grab_tile.sv
// Copies a TILE_W x TILE_H region of the RGB565 framebuffer into linear tile RAM,
// one read per cycle, pipelined over RD_LAT cycles. Clipping: GRAB_TILE_CLIP_EN.
module grab_tile
  import grab_tile_pkg::*;
#(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [ADDR_W-1:0] tile_addr,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_data,
  output logic              dst_wr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [15:0]       dst_data
);

  localparam int               NPIX       = TILE_W * TILE_H;
  localparam int               CNT_W      = $clog2(NPIX);
  localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              capture;
  logic              issue;
  logic [9:0]        x_q, y_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_clip;

  // One slot per outstanding read; slot RD_LAT-1 lines up with src_data.
  logic [RD_LAT-1:0]            pv;
  logic [RD_LAT-1:0]            pclip;
  logic [RD_LAT-1:0][CNT_W-1:0] pidx;

  grab_addr_gen #(
    .TILE_W (TILE_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .x        (x_q),
    .y        (y_q),
    .cnt      (cnt),
    .src_addr (gen_addr),
    .clip     (gen_clip)
  );

  // NOTE: every register below uses <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      pv     <= '0;
      pclip  <= '0;
      pidx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (capture) begin
        x_q    <= x;
        y_q    <= y;
        base_q <= tile_addr;
      end
      pv[0]    <= issue;
      pclip[0] <= gen_clip;
      pidx[0]  <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]    <= pv[i-1];
        pclip[i] <= pclip[i-1];
        pidx[i]  <= pidx[i-1];
      end
    end
  end

  // NOTE: defaults first so no path through the case leaves a latch behind.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    capture  = 1'b0;
    issue    = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      S_READ: begin
        issue = 1'b1;
        if (cnt == LAST_PIX) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    src_rd   = issue & ~gen_clip;
    src_addr = issue ? gen_addr : '0;
  end

  assign dst_wr   = pv[RD_LAT-1];
  assign dst_addr = dst_wr ? base_q + ADDR_W'(pidx[RD_LAT-1]) : '0;
  assign dst_data = !dst_wr            ? 16'h0000 :
                    pclip[RD_LAT-1]    ? KEY_COLOR : src_data;

endmodule

// File: tb/tb_grab_tile.sv
// Self-checking bench for grab_tile: framebuffer model returns addr[15:0],
// an index-level model predicts every output each cycle, plus literal pins.
module tb_grab_tile;

  localparam int TW  = 32;
  localparam int TH  = 32;
  localparam int LAT = 2;
  localparam int N   = TW * TH;
`ifdef GRAB_TILE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        start;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [18:0] tile_addr;
  logic        busy;
  logic        done;
  logic        src_rd;
  logic [18:0] src_addr;
  logic [15:0] src_data;
  logic        dst_wr;
  logic [18:0] dst_addr;
  logic [15:0] dst_data;

  int n_checks = 0;
  int n_errors = 0;

  grab_tile #(
    .TILE_W (TW),
    .TILE_H (TH),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .x         (x),
    .y         (y),
    .tile_addr (tile_addr),
    .busy      (busy),
    .done      (done),
    .src_rd    (src_rd),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .dst_wr    (dst_wr),
    .dst_addr  (dst_addr),
    .dst_data  (dst_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency framebuffer: data = requested address low 16 bits.
  logic [15:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= src_rd ? src_addr[15:0] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign src_data = rd_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of an accepted grab: when it started and with which latched inputs.
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  int          m_x = 0;
  int          m_y = 0;
  int          m_base = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_active <= 1'b0;
    else if (start && (!m_active || (cyc - m_t0) >= N + LAT + 2)) begin
      m_active <= 1'b1;
      m_t0     <= cyc;
      m_x      <= int'(x);
      m_y      <= int'(y);
      m_base   <= int'(tile_addr);
    end
  end

  logic [18:0] rd_log      [N];
  bit          rd_seen     [N];
  logic [18:0] wr_addr_log [N];
  logic [15:0] wr_data_log [N];
  int          n_wr = 0;
  int          n_done = 0;
  int          done_rel = -1;

  function automatic void pix(input int px, input int py, input int i,
                              output int addr, output bit clipped);
    int col, row;
    col     = px + i % TW;
    row     = py + i / TW;
    addr    = (row * 640 + col) % (1 << 19);
    clipped = CLIP_EN && (col >= 640 || row >= 480);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    logic [57:0] act, exp, msk;
    logic        e_busy, e_done, e_rd, e_wr;
    logic [18:0] e_sa, e_da;
    logic [15:0] e_dd;
    bit          m_sa, m_w, c;
    int          rel, a, i;
    @(negedge clk);
    e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
    e_sa = '0; e_da = '0; e_dd = '0; m_sa = 0; m_w = 0;
    rel = cyc - m_t0;
    if (m_active) begin
      e_busy = (rel >= 1 && rel <= N + LAT + 1);
      e_done = (rel == N + LAT + 1);
      if (rel >= 1 && rel <= N) begin
        i = rel - 1;
        pix(m_x, m_y, i, a, c);
        e_rd = !c;
        m_sa = !c;
        e_sa = 19'(a);
        rd_log[i]  = src_addr;
        rd_seen[i] = src_rd;
      end
      if (rel >= LAT + 1 && rel <= N + LAT) begin
        i = rel - LAT - 1;
        pix(m_x, m_y, i, a, c);
        e_wr = 1; m_w = 1;
        e_da = 19'((m_base + i) % (1 << 19));
        e_dd = c ? 16'hF81F : 16'(a);
        wr_addr_log[i] = dst_addr;
        wr_data_log[i] = dst_data;
      end
    end
    if (dst_wr) n_wr++;
    if (done) begin
      n_done++;
      done_rel = rel;
    end
    act = {busy, done, src_rd, dst_wr, src_addr, dst_addr, dst_data};
    exp = {e_busy, e_done, e_rd, e_wr, e_sa, e_da, e_dd};
    msk = {4'hF, m_sa ? 19'h7FFFF : 19'h0, m_w ? 19'h7FFFF : 19'h0, m_w ? 16'hFFFF : 16'h0};
    n_checks++;
    if (((act ^ exp) & msk) != '0) begin
      n_errors++;
      $display("FAIL cycle rel=%0d: got %0h expected %0h (mask %0h)", rel, act, exp, msk);
    end
  endtask

  task automatic launch(input logic [9:0] gx, input logic [9:0] gy, input logic [18:0] gbase);
    start = 1'b1; x = gx; y = gy; tile_addr = gbase;
    tick();
    start = 1'b0; x = ~gx; y = ~gy; tile_addr = ~gbase;
  endtask

  task automatic wait_done(input int bound);
    int d0, k;
    d0 = n_done; k = 0;
    while (n_done == d0 && k < bound) begin
      tick();
      k++;
    end
    check("done_seen", 64'(n_done - d0), 64'd1);
    repeat (3) tick();
  endtask

  initial begin
    int w0, d0, s;
    rstn = 1'b0; start = 1'b0; x = '0; y = '0; tile_addr = '0;
    #1;
    check("reset_outputs", 64'({busy, done, src_rd, dst_wr, src_addr, dst_addr, dst_data}), 64'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    // Origin grab: timing and data pins.
    w0 = n_wr;
    launch(10'd0, 10'd0, 19'h40000);
    wait_done(N + 100);
    check("a_writes", 64'(n_wr - w0), 64'd1024);
    check("a_first_addr", 64'(wr_addr_log[0]), 64'h40000);
    check("a_first_data", 64'(wr_data_log[0]), 64'd0);
    check("a_idx33_data", 64'(wr_data_log[33]), 64'd641);
    check("a_done_cycle", 64'(done_rel), 64'd1027);

    // Offset origin: address arithmetic.
    launch(10'd100, 10'd50, 19'h00100);
    wait_done(N + 100);
    check("b_first_src", 64'(rd_log[0]), 64'd32100);
    check("b_idx32_src", 64'(rd_log[32]), 64'd32740);

    // Restart attempts while busy and on the FIN cycle; base wraps 2^19.
    w0 = n_wr; d0 = n_done;
    launch(10'd5, 10'd9, 19'h7FFF0);
    while (cyc - m_t0 < 5) tick();
    start = 1'b1; x = 10'd7;
    tick();
    start = 1'b0;
    while (cyc - m_t0 < 500) tick();
    start = 1'b1; y = 10'd300;
    tick();
    start = 1'b0;
    while (cyc - m_t0 < N + LAT + 1) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("c_writes", 64'(n_wr - w0), 64'd1024);
    check("c_dones", 64'(n_done - d0), 64'd1);
    check("c_wrap_addr", 64'(wr_addr_log[N-1]), 64'h003EF);

    // Reset during the 300th write aborts without done.
    d0 = n_done;
    launch(10'd3, 10'd4, 19'h01000);
    while (cyc - m_t0 < LAT + 300) tick();
    #2 rstn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_dst_wr", 64'(dst_wr), 64'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (N + 50) tick();
    check("abort_no_done", 64'(n_done - d0), 64'd0);

    // Full grab after the abort.
    w0 = n_wr;
    launch(10'd0, 10'd0, 19'h20000);
    wait_done(N + 100);
    check("e_writes", 64'(n_wr - w0), 64'd1024);

    // Tile hanging off the bottom-right corner.
    w0 = n_wr;
    launch(10'd620, 10'd470, 19'h00000);
    wait_done(N + 100);
    s = 0;
    for (int i = 0; i < N; i++) s += int'(rd_seen[i]);
    check("f_writes", 64'(n_wr - w0), 64'd1024);
    check("f_first_src", 64'(rd_log[0]), 64'd301420);
    check("f_first_data", 64'(wr_data_log[0]), 64'h996C);
    if (CLIP_EN) begin
      check("f_reads_clip", 64'(s), 64'd200);
      check("f_col20_key", 64'(wr_data_log[20]), 64'hF81F);
      check("f_row10_key", 64'(wr_data_log[10*TW]), 64'hF81F);
    end else begin
      check("f_reads_all", 64'(s), 64'd1024);
      check("f_last_src", 64'(rd_log[N-1]), 64'd321291);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grab_tile.md
Name: grab_tile

Overview:
- Inverse of the tile renderer: copies a TILE_W x TILE_H pixel region out of the RGB565 framebuffer into a linear tile buffer.
- Used for background save/restore under sprites and for screenshot-to-tile.
- Sits between the framebuffer read port (source) and the tile/sprite RAM write port (destination).
- Runs from a start pulse; one pixel read issued per cycle; pipelined against a fixed-latency framebuffer read.

Parameters:
- TILE_W, 32, tile width in pixels (power of 2)
- TILE_H, 32, tile height in pixels
- FB_W, 640, framebuffer width in pixels
- FB_H, 480, framebuffer height in pixels
- RD_LAT, 2, framebuffer read latency in cycles (src_data valid RD_LAT cycles after src_rd/src_addr)
- KEY_COLOR, 16'hF81F, fill value for clipped pixels

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin grab; sampled only in IDLE
- x  in  10  framebuffer column of tile top-left; captured at start
- y  in  10  framebuffer row of tile top-left; captured at start
- tile_addr  in  19  destination base address; captured at start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last write
- src_rd  out  1  framebuffer read strobe
- src_addr  out  19  framebuffer address = row*FB_W + col
- src_data  in  16  framebuffer read data, RGB565
- dst_wr  out  1  tile RAM write strobe
- dst_addr  out  19  tile RAM address = tile_addr + pixel index
- dst_data  out  16  tile RAM write data

Behaviour:
- Reset (async, rstn=0):
  - State IDLE.
  - busy, done, src_rd and dst_wr are 0.
  - src_addr, dst_addr and dst_data are 0.
  - Pipeline valid bits cleared.
- Reset mid-operation aborts immediately: no further writes, no done pulse.
- FSM states: IDLE -> READ -> DRAIN -> FIN -> IDLE.
  - IDLE: start=1 latches x, y and tile_addr, clears cnt, and moves to READ. busy=0.
  - READ:
    - Each cycle, src_rd=1 with src_addr for pixel cnt, where col = x + cnt[log2(TILE_W)-1:0] and row = y + cnt/TILE_W.
    - cnt increments.
    - After cnt = TILE_W*TILE_H-1 is issued, go to DRAIN.
  - DRAIN: src_rd=0 for RD_LAT cycles, then FIN.
  - FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Pipeline:
  - A shift register of depth RD_LAT carries {valid, index, clip} per issued read.
  - If a read is issued in cycle k, then in cycle k+RD_LAT: dst_wr=1, dst_addr = tile_addr + index, dst_data = src_data (or KEY_COLOR if clipped).
  - Writes are strictly sequential, one per cycle, with no gaps.
- Timing:
  - Total busy cycles = TILE_W*TILE_H + RD_LAT + 1.
  - First write occurs RD_LAT cycles after the first read.
- Arithmetic:
  - row*FB_W is computed in 19 bits.
  - col and row are 11 bits, so overflow is detectable.
  - Address sums wrap modulo 2^19.
- start while busy: ignored. start on the FIN cycle: ignored. start is accepted on the first IDLE cycle.
- x and y inputs may change freely after start; the latched copies are used.

Optional Feature:
- Macro GRAB_TILE_CLIP_EN.
- Defined:
  - Pixels with col >= FB_W or row >= FB_H are clipped.
  - No read is issued for a clipped pixel (src_rd=0 that cycle).
  - The write still occurs at the same pipeline slot with dst_data = KEY_COLOR.
- Undefined:
  - No bounds check; every pixel is read.
  - Out-of-range coordinates produce the unchecked, wrapped address.

Decomposition:
- FB_W, FB_H, KEY_COLOR and the 19-bit address width go in the shared parameter.v include already used by the render blocks.
- One natural sub-module: grab_addr_gen, a combinational block mapping (x, y, cnt) to {src_addr, clip}.
  - Reusable by a future scanout block.
- The FSM and pipeline stay in grab_tile.

Test Plan:
- Memory model RD_LAT=2 returning data = addr[15:0]. Start x=0, y=0, tile_addr=19'h40000:
  - 1024 writes observed.
  - First write dst_addr=19'h40000, dst_data=0.
  - Write index 33: dst_data=641.
  - done pulses at cycle 1027 after start.
- x=100, y=50: the first src_addr = 50*640+100 = 32100. Index 32 reads 32740.
- Start pulsed again at cycles 5 and 500 while busy: no restart, exactly 1024 writes, single done.
- rstn dropped at write 300: busy=0, dst_wr=0 immediately. No done. The next start runs a complete 1024-write grab.
- With GRAB_TILE_CLIP_EN, x=620, y=470:
  - Columns 20..31 and rows 10..31 are written as 16'hF81F with no src_rd.
  - Pixel (0,0) reads addr 301420.
- Without the macro, same x, y:
  - All 1024 reads issued.
  - Pixel (31,31) src_addr = (501*640+651) mod 2^19 = 321291.
